bcd_seg_scan: RTL
=================

# bcd_seg_scan

Time-multiplexed seven-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures a packed BCD word (three 4-bit digits, hundreds in the top nibble) on a load strobe and holds it. It then scans the digits onto a common-anode display, one digit at a time, at a parameterised refresh rate. Leading-zero blanking and invalid-digit indication are included.

## Interface
- DIGITS, 3: number of BCD digits scanned; bcd_in width is 4*DIGITS.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled (dwell); minimum 2.
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- bcd_in  input  4*DIGITS  packed BCD; nibble k = digit k, with digit 0 the least significant.
- load  input  1  when high on a clock edge, bcd_in is captured into the hold register.
- blank_lz  input  1  enables leading-zero blanking; sampled every cycle, not latched.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  DIGITS  digit enables, active-low, one-cold.
- frame  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Hold register:
  - Reset value is 0.
  - On load it takes bcd_in; otherwise it holds.
  - No handshake or backpressure; load may be asserted every cycle.
- Dwell counter:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - At the wrap, the digit index idx advances: 0→1→…→DIGITS-1→0.
- Digit decode (values are seg, active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Nibble values 10–15 display a dash: 0x3F.
  - A blanked digit shows 0x7F.
- Leading-zero blanking, applied when blank_lz=1:
  - Digit k (k>0) is blanked iff every nibble from k to DIGITS-1 equals 0.
  - Digit 0 is never blanked, so a value of 0 displays as a single "0".
  - An invalid nibble counts as non-zero.
- an: the bit for idx is 0 and all other bits are 1. an is still driven for a blanked digit; only seg shows blank.

## Timing
- Reset values, while rst_n=0 and on the first edge after it:
  - seg=0x7F, an=all ones, frame=0.
  - Hold register=0, counter=0, idx=0.
- seg, an and frame are registered. They reflect the idx and hold-register state of the previous cycle.
  - First cycle after reset release: an=…110, seg shows digit 0 of the held value (0x40).
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- Load latency: a capture at edge N changes seg at edge N+1 if the affected digit is currently selected.
- A load does not disturb the counter or idx.
- Load coinciding with a digit switch: both take effect, and the newly selected digit shows the newly loaded value.
- frame is asserted for the single cycle in which an first selects digit 0 after digit DIGITS-1. It is not asserted after reset.
- A reset in mid-dwell or mid-frame returns to the reset values at the next edge. The scan restarts at digit 0 with a full dwell.

## Structure
- Package seg_pkg holds:
  - the segment constants (SEG_0..SEG_9, SEG_DASH=0x3F, SEG_BLANK=0x7F);
  - the active-low polarity constants.
- Sub-module bcd_to_seg: combinational nibble-plus-blank to seg decoder, using the seg_pkg constants. It is instantiated once, on the selected nibble.
- Top level contains:
  - the hold register;
  - the dwell counter, with width clog2(REFRESH_DIV);
  - the idx counter;
  - the leading-zero mask;
  - the output registers.

## Test plan
All scenarios use DIGITS=3, REFRESH_DIV=4.
- Reset then idle:
  - Hold rst_n=0 for 3 cycles → seg=0x7F, an=111 throughout.
  - After release → an sequence 110×4, 101×4, 011×4, 110…; seg=0x40 on each digit (blank_lz=0); frame high on the cycle an returns to 110.
- Load 0x255, blank_lz=0 → digit0 seg=0x12, digit1 seg=0x12, digit2 seg=0x24.
- Leading-zero blanking:
  - Load 0x007, blank_lz=1 → digit0=0x78, digit1=0x7F, digit2=0x7F.
  - Load 0x000 → digit0=0x40, others 0x7F.
  - Load 0x105 → digit1 shows 0x40 (not blanked).
- Invalid nibble: load 0x1A3 → digit1 seg=0x3F; with blank_lz=1, digit2 shows 0x79.
- Load during dwell:
  - While digit0 is selected, load changes 0x001→0x009 → seg goes 0x79→0x10 on the next edge; the an dwell count is unaffected.
  - Load on the switch cycle → the new digit shows the new value immediately.
- Mid-frame reset: assert rst_n=0 for one cycle while an=101 → next edge gives seg=0x7F, an=111, hold=0; the scan restarts at an=110 for a full 4 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the BCD seven-segment scan driver.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Display-driver bus: BCD word and controls in, segment scan out.
// The design takes the slave side.
interface bcd_seg_scan_if #(
  parameter int DIGITS = 3
);

  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic                blank_lz;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output bcd_in, load, blank_lz,
    input  seg, an, frame
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output seg, an, frame
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational nibble-to-segment decoder.
// Nibbles 10..15 show a dash; blank overrides everything.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed common-anode display driver with
// leading-zero blanking and registered scan outputs.
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_seg_scan_if.slave   bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] hold_q, hold_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                tick;
  logic [DIGITS-1:0]   lz;
  logic                zacc;
  logic [3:0]          nib;
  logic                blank_sel;
  logic [6:0]          seg_dec;

  always_comb begin
    hold_d = bus.load ? bus.bcd_in : hold_q;
    tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    wrap_d = tick && (idx_q == IW'(DIGITS - 1));
  end

  // lz[k]: nibbles k..DIGITS-1 are all zero; digit 0 never blanks
  always_comb begin
    lz   = '0;
    zacc = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zacc  = zacc && (hold_q[4*k +: 4] == 4'd0);
      lz[k] = zacc;
    end
  end

  always_comb begin
    nib       = hold_q[4*idx_q +: 4];
    blank_sel = bus.blank_lz && lz[idx_q];
  end

  bcd_to_seg u_dec (
    .nib   (nib),
    .blank (blank_sel),
    .seg   (seg_dec)
  );

  always_comb begin
    seg_d        = seg_dec;
    an_d         = {DIGITS{AN_OFF}};
    an_d[idx_q]  = AN_ON;
    frame_d      = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= {DIGITS{AN_OFF}};
      frame_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule
